ntt_agu: RTL and testbench



---
 rtl/ntt_pkg.sv | 39 +++
 rtl/ntt_agu_if.sv | 28 ++
 rtl/ntt_bank_map.sv | 23 ++
 rtl/ntt_agu.sv | 131 +++++++++++++
 tb/tb_ntt_agu.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and index helper for the NTT address path.
package ntt_pkg;

  localparam int N_LOG   = 12;                // log2 of polynomial degree
  localparam int K       = 4;                 // log2 of radix / bank count
  localparam int R       = 1 << K;            // lanes and banks
  localparam int STAGES  = N_LOG / K;         // iteration stages
  localparam int GROUPS  = 1 << (N_LOG - K);  // butterfly groups per stage
  localparam int MA_W    = N_LOG - K;         // per-lane memory address width
  localparam int GROUP_W = N_LOG - K;         // group counter width
  localparam int STAGE_W = 2;                 // stage counter / stage_out width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } agu_state_t;

  // Coefficient index for stage s, group j, lane l: the lane occupies digit s,
  // group bits below that digit stay in place, group bits above it move up
  // by one digit to make room for the lane field.
  function automatic logic [N_LOG-1:0] build_idx(
    input logic [STAGE_W-1:0] s,
    input logic [GROUP_W-1:0] j,
    input logic [K-1:0]       l
  );
    logic [N_LOG-1:0] wide_j;
    logic [N_LOG-1:0] wide_l;
    logic [N_LOG-1:0] low_mask;
    int unsigned      sh;
    sh       = int'(s) * K;
    wide_j   = {{K{1'b0}}, j};
    wide_l   = {{(N_LOG-K){1'b0}}, l};
    low_mask = (N_LOG'(1) << sh) - N_LOG'(1);
    build_idx = ((wide_j & ~low_mask) << K) | (wide_l << sh) | (wide_j & low_mask);
  endfunction

endpackage

// File: rtl/ntt_agu_if.sv
// Bus between the address generation unit and the NTT controller.
interface ntt_agu_if;
  import ntt_pkg::*;

  // Handshake: AGU_enable is a level request from the controller; while it is
  // high in RUN one group is issued per cycle. BN_MA_out_en is a pure valid
  // strobe with no ready: the pipeline never stalls, so the controller must
  // take bn_out/ma_out/stage_out in every cycle the strobe is high.
  // AGU_done is a single-cycle pulse one cycle after the final strobe.
  logic              AGU_enable;
  logic              BN_MA_out_en;
  logic [R*K-1:0]    bn_out;
  logic [R*MA_W-1:0] ma_out;
  logic [STAGE_W-1:0] stage_out;
  logic              AGU_done;
  agu_state_t        state;      // FSM state, exported for observation

  modport master (
    input  AGU_enable,
    output BN_MA_out_en, bn_out, ma_out, stage_out, AGU_done, state
  );

  modport slave (
    output AGU_enable,
    input  BN_MA_out_en, bn_out, ma_out, stage_out, AGU_done, state
  );

endinterface

// File: rtl/ntt_bank_map.sv
// Single-lane index -> (bank number, memory address) map.
module ntt_bank_map
  import ntt_pkg::*;
(
  input  logic [N_LOG-1:0] idx,
  output logic [K-1:0]     bn,
  output logic [MA_W-1:0]  ma
);

  logic [K-1:0] digit_sum;

  // Sum of all K-bit digits, kept to K bits so the result wraps mod R.
  always_comb begin
    digit_sum = '0;
    for (int d = 0; d < STAGES; d++) begin
      digit_sum = digit_sum + idx[d*K +: K];
    end
  end

  assign bn = digit_sum;
  assign ma = idx[N_LOG-1:K];

endmodule

// File: rtl/ntt_agu.sv
// Address generation unit: walks every group of every stage and emits the
// per-lane bank numbers and addresses through a two-stage pipeline.
module ntt_agu
  import ntt_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ntt_agu_if.master bus
);

  if ((N_LOG % K) != 0) begin : g_bad_cfg
    $error("ntt_agu: N_LOG must be an exact multiple of K");
  end

  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(GROUPS - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);

  agu_state_t          state;
  logic [STAGE_W-1:0]  stage_cnt;
  logic [GROUP_W-1:0]  group_cnt;
  logic                done_q;
  logic                issue;

  logic                p1_valid;
  logic [STAGE_W-1:0]  p1_stage;
  logic [N_LOG-1:0]    p1_idx [R];

  logic [K-1:0]        lane_bn [R];
  logic [MA_W-1:0]     lane_ma [R];

  logic                p2_valid;
  logic [STAGE_W-1:0]  p2_stage;
  logic [R*K-1:0]      p2_bn;
  logic [R*MA_W-1:0]   p2_ma;

  // A group is issued only in RUN and only while the controller enables us.
  assign issue = (state == RUN) && bus.AGU_enable;

  // Control FSM with group/stage counters and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage_cnt <= '0;
      group_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.AGU_enable) state <= RUN;
        end
        RUN: begin
          if (bus.AGU_enable) begin
            if (group_cnt == LAST_GROUP) begin
              group_cnt <= '0;
              if (stage_cnt == LAST_STAGE) begin
                stage_cnt <= '0;
                state     <= DRAIN;
              end else begin
                stage_cnt <= stage_cnt + STAGE_W'(1);
              end
            end else begin
              group_cnt <= group_cnt + GROUP_W'(1);
            end
          end
        end
        DRAIN: begin
          // Nothing is issued here, so once P1 is empty the entry now in P2
          // is the last one; pulse done to line up with the cycle after it.
          if (!p1_valid) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!bus.AGU_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // P1 valid bit, cleared on reset so in-flight entries are dropped.
  always_ff @(posedge clk) begin
    if (rst) p1_valid <= 1'b0;
    else     p1_valid <= issue;
  end

  // P1 data: per-lane index and the stage tag of the issued group.
  always_ff @(posedge clk) begin
    if (issue) begin
      p1_stage <= stage_cnt;
      for (int l = 0; l < R; l++) begin
        p1_idx[l] <= build_idx(stage_cnt, group_cnt, K'(l));
      end
    end
  end

  for (genvar l = 0; l < R; l++) begin : g_lane
    ntt_bank_map u_map (
      .idx (p1_idx[l]),
      .bn  (lane_bn[l]),
      .ma  (lane_ma[l])
    );
  end

  // P2 output registers; data is forced to zero whenever the entry is invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      p2_valid <= 1'b0;
      p2_stage <= '0;
      p2_bn    <= '0;
      p2_ma    <= '0;
    end else begin
      p2_valid <= p1_valid;
      p2_stage <= p1_valid ? p1_stage : '0;
      for (int l = 0; l < R; l++) begin
        p2_bn[l*K +: K]       <= p1_valid ? lane_bn[l] : '0;
        p2_ma[l*MA_W +: MA_W] <= p1_valid ? lane_ma[l] : '0;
      end
    end
  end

  assign bus.BN_MA_out_en = p2_valid;
  assign bus.bn_out       = p2_bn;
  assign bus.ma_out       = p2_ma;
  assign bus.stage_out    = p2_stage;
  assign bus.AGU_done     = done_q;
  assign bus.state        = state;

endmodule

// File: tb/tb_ntt_agu.sv
// Directed bench for ntt_agu: full runs, pause/resume, abort and restart.
module tb_ntt_agu;
  import ntt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_agu_if bus ();

  ntt_agu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [9:0]   exp_q[$];      // {stage[1:0], group[7:0]} in emission order
  logic [63:0]  cap_bn[$];
  logic [127:0] cap_ma[$];
  logic [1:0]   cap_stage[$];
  int valid_cnt = 0;
  int done_cnt  = 0;
  logic prev_en = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: build the three 4-bit digits explicitly, lane in digit s,
  // group digits filling the other positions from low to high.
  function automatic void model(input int s, input int j, output logic [63:0] bn,
                                output logic [127:0] ma);
    int d [3];
    int jd;
    int idx;
    bn = '0;
    ma = '0;
    for (int l = 0; l < 16; l++) begin
      jd = j;
      for (int p = 0; p < 3; p++) begin
        if (p == s) d[p] = l;
        else begin
          d[p] = jd % 16;
          jd = jd / 16;
        end
      end
      idx = d[0] + 16 * d[1] + 256 * d[2];
      bn[l*4 +: 4] = 4'((d[0] + d[1] + d[2]) % 16);
      ma[l*8 +: 8] = 8'(idx / 16);
    end
  endfunction

  // Monitor: every valid must match the next expected group, in order.
  always @(negedge clk) begin : mon
    logic [9:0]   tok;
    logic [63:0]  ebn;
    logic [127:0] ema;
    logic [15:0]  seen;
    logic [63:0]  obn;
    if (rst === 1'b1) begin
      prev_en = 1'b0;
    end else begin
      if (bus.BN_MA_out_en === 1'b1) begin
        valid_cnt++;
        cap_bn.push_back(bus.bn_out);
        cap_ma.push_back(bus.ma_out);
        cap_stage.push_back(bus.stage_out);
        check_eq("valid_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          tok = exp_q.pop_front();
          model(int'(tok[9:8]), int'(tok[7:0]), ebn, ema);
          check_eq("bn_out", 128'(bus.bn_out), 128'(ebn));
          check_eq("ma_out", bus.ma_out, ema);
          check_eq("stage_out", 128'(bus.stage_out), 128'(tok[9:8]));
        end
        seen = '0;
        obn  = bus.bn_out;
        for (int l = 0; l < 16; l++) seen[obn[l*4 +: 4]] = 1'b1;
        check_eq("bn_distinct", 128'(seen), 128'(16'hFFFF));
      end
      if (bus.AGU_done === 1'b1) begin
        done_cnt++;
        check_eq("done_after_last_valid", 128'(prev_en), 128'(1));
        check_eq("done_queue_empty", 128'(exp_q.size()), 128'(0));
      end
      prev_en = bus.BN_MA_out_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_run();
    exp_q.delete();
    cap_bn.delete();
    cap_ma.delete();
    cap_stage.delete();
    valid_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic preload_run();
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 256; j++)
        exp_q.push_back({2'(s), 8'(j)});
  endtask

  task automatic wait_done(input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (bus.AGU_done === 1'b1) got = 1;
    end
    check_eq("done_seen", 128'(got), 128'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_en"},    128'(bus.BN_MA_out_en), 128'(0));
    check_eq({tag, "_bn"},    128'(bus.bn_out), 128'(0));
    check_eq({tag, "_ma"},    bus.ma_out, 128'(0));
    check_eq({tag, "_stage"}, 128'(bus.stage_out), 128'(0));
    check_eq({tag, "_done"},  128'(bus.AGU_done), 128'(0));
    check_eq({tag, "_state"}, 128'(bus.state), 128'(IDLE));
  endtask

  task automatic check_full_run(input string tag);
    repeat (2) @(negedge clk);
    check_eq({tag, "_valid_cnt"}, 128'(valid_cnt), 128'(768));
    check_eq({tag, "_done_cnt"},  128'(done_cnt), 128'(1));
    check_eq({tag, "_q_empty"},   128'(exp_q.size()), 128'(0));
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0]  vbn;
    logic [127:0] vma;
    int cnt_drop;
    int done_before;

    rst = 1'b1;
    bus.AGU_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Full run with enable held high; first valid two cycles after RUN entry.
    clear_run();
    preload_run();
    @(posedge clk); #1 bus.AGU_enable = 1'b1;
    @(posedge clk);                      // IDLE -> RUN
    @(negedge clk);
    check_eq("run_entry_state", 128'(bus.state), 128'(RUN));
    check_eq("lat_cycle0", 128'(bus.BN_MA_out_en), 128'(0));
    @(negedge clk);
    check_eq("lat_cycle1", 128'(bus.BN_MA_out_en), 128'(0));
    @(negedge clk);
    check_eq("lat_cycle2", 128'(bus.BN_MA_out_en), 128'(1));
    wait_done(2000);
    check_full_run("run1");

    vbn = cap_bn[0];   check_eq("s0g0_bn", 128'(vbn), 128'(64'hFEDC_BA98_7654_3210));
    vma = cap_ma[0];   check_eq("s0g0_ma", vma, 128'(0));
    vbn = cap_bn[1];   check_eq("s0g1_bn", 128'(vbn), 128'(64'h0FED_CBA9_8765_4321));
    vma = cap_ma[1];   check_eq("s0g1_ma", vma, 128'h0101_0101_0101_0101_0101_0101_0101_0101);
    vbn = cap_bn[257]; check_eq("s1g1_bn", 128'(vbn), 128'(64'h0FED_CBA9_8765_4321));
    vma = cap_ma[257]; check_eq("s1g1_ma", vma, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    vbn = cap_bn[547]; check_eq("s2g23_l5_bn", 128'(vbn[23:20]), 128'(4'hA));
    vma = cap_ma[547]; check_eq("s2g23_l5_ma", 128'(vma[47:40]), 128'(8'h52));
    check_eq("stage_tag_255", 128'(cap_stage[255]), 128'(0));
    check_eq("stage_tag_256", 128'(cap_stage[256]), 128'(1));
    check_eq("stage_tag_767", 128'(cap_stage[767]), 128'(2));

    // Enable still high after done: nothing more may come out.
    repeat (10) @(negedge clk);
    check_eq("post_done_valid_cnt", 128'(valid_cnt), 128'(768));
    check_eq("post_done_done_cnt",  128'(done_cnt), 128'(1));
    check_eq("post_done_state",     128'(bus.state), 128'(DONE));

    // Enable low -> IDLE, then a new run paused after the 256th issue.
    @(posedge clk); #1 bus.AGU_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("done_to_idle", 128'(bus.state), 128'(IDLE));
    clear_run();
    preload_run();
    @(posedge clk); #1 bus.AGU_enable = 1'b1;
    @(posedge clk);                      // IDLE -> RUN
    repeat (256) @(posedge clk);
    #1 bus.AGU_enable = 1'b0;
    cnt_drop = valid_cnt;
    check_eq("pause_cnt_at_drop", 128'(cnt_drop), 128'(254));
    repeat (11) @(posedge clk);
    @(negedge clk);
    check_eq("pause_trailing", 128'(valid_cnt - cnt_drop), 128'(2));
    check_eq("pause_state", 128'(bus.state), 128'(RUN));
    check_eq("pause_no_valid", 128'(bus.BN_MA_out_en), 128'(0));
    bus.AGU_enable = 1'b1;
    wait_done(2000);
    check_full_run("run2");

    // Abort with reset at stage 1 group 100, then a fresh run.
    @(posedge clk); #1 bus.AGU_enable = 1'b0;
    repeat (2) @(posedge clk);
    clear_run();
    preload_run();
    #1 bus.AGU_enable = 1'b1;
    @(posedge clk);                      // IDLE -> RUN
    repeat (357) @(posedge clk);         // issues 0..356 taken
    #1 rst = 1'b1;
    bus.AGU_enable = 1'b0;
    done_before = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("abort");
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("abort_no_done", 128'(done_cnt), 128'(done_before));
    check_eq("abort_still_idle", 128'(bus.state), 128'(IDLE));

    clear_run();
    preload_run();
    @(posedge clk); #1 bus.AGU_enable = 1'b1;
    wait_done(2000);
    check_full_run("run3");
    vbn = cap_bn[0];
    check_eq("restart_s0g0_bn", 128'(vbn), 128'(64'hFEDC_BA98_7654_3210));
    check_eq("restart_stage0", 128'(cap_stage[0]), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
